// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register indices, flag positions and sizing helper for the CPU register file
package cpu_pkg;

  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_cpsr.sv
// rtl/cpu_cpsr.sv - masked NZCV flag register presented as CPSR with zeroed low bits
module cpu_cpsr
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [NUM_FLAGS-1:0] flag_we,
  input  logic [NUM_FLAGS-1:0] flag_in,
  output logic [DATA_W-1:0]    cpsr
);

  logic [NUM_FLAGS-1:0] flags;

  // Each flag takes its new value only where its mask bit is set; stall freezes all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (!hold) begin
      flags <= (flags & ~flag_we) | (flag_in & flag_we);
    end
  end

  assign cpsr = {flags, {(DATA_W - NUM_FLAGS){1'b0}}};

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - architectural register file with PC sequencing, link and CPSR; CPU_REGFILE_BYPASS_EN enables write-through reads
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 NUM_REGS = 16,
  parameter int                 NUM_RD   = 3,
  parameter int                 PC_STEP  = 1,
  parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(8'hFF),
  localparam int                AW       = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     pc_inc,
  input  logic                     br_en,
  input  logic                     br_link,
  input  logic [DATA_W-1:0]        br_target,
  input  logic [3:0]               flag_we,
  input  logic [3:0]               flag_in,
  input  logic                     hold,
  output logic [DATA_W-1:0]        pc,
  output logic [DATA_W-1:0]        cpsr
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
  localparam logic [AW-1:0]     A_PC = AW'(REG_PC);

  // r15 lives in the array so reads of the PC need no special case.
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] nxt  [NUM_REGS];
  logic              pc_wr;

  assign pc_wr = (wa_en && (wa_addr == A_PC)) || (wb_en && (wb_addr == A_PC));

  // Next architectural state: B then A (A wins), link overrides r14, PC by priority.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      nxt[i] = regs[i];
      if (wb_en && (wb_addr == AW'(i))) nxt[i] = wb_data;
      if (wa_en && (wa_addr == AW'(i))) nxt[i] = wa_data;
    end
    if (br_en && br_link) nxt[REG_LR] = regs[REG_PC] + STEP;
    if (br_en) begin
      nxt[REG_PC] = br_target;
    end else if (!pc_wr && pc_inc) begin
      nxt[REG_PC] = regs[REG_PC] + STEP;
    end
  end

  // Register array update; reset clears everything except the stack pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_SP) ? SP_RESET : '0;
      end
    end else if (!hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= nxt[i];
      end
    end
  end

  // Combinational read ports; write-through variant shows the value about to be committed.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef CPU_REGFILE_BYPASS_EN
      rd_data[k*DATA_W +: DATA_W] = (reset && !hold) ? nxt[rd_addr[k*AW +: AW]]
                                                      : regs[rd_addr[k*AW +: AW]];
`else
      rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*AW +: AW]];
`endif
    end
  end

  assign pc = regs[REG_PC];

  cpu_cpsr #(
    .DATA_W(DATA_W)
  ) u_cpsr (
    .clk    (clk),
    .reset  (reset),
    .hold   (hold),
    .flag_we(flag_we),
    .flag_in(flag_in),
    .cpsr   (cpsr)
  );

endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
Parametrised architectural register file for the CPU core: general registers, SP, LR, PC and CPSR. Provides NUM_RD combinational read ports, two synchronous write ports (ALU result, load/link), PC sequencing (increment, branch, branch-with-link) and masked CPSR flag updates. Sits between decode/control and the ALU/load-store path.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 16, number of architectural registers (power of 2, >=16)
NUM_RD, 3, number of read ports
PC_STEP, 1, PC increment per instruction, in DATA_W units
SP_RESET, 8'hFF, SP (r13) reset value, truncated/extended to DATA_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
rd_addr  in  NUM_RD*log2(NUM_REGS)  packed read addresses, port k at slice k
rd_data  out  NUM_RD*DATA_W  packed read data
wa_en  in  1  write port A enable (ALU)
wa_addr  in  log2(NUM_REGS)  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load/link)
wb_addr  in  log2(NUM_REGS)  write port B address
wb_data  in  DATA_W  write port B data
pc_inc  in  1  advance PC by PC_STEP
br_en  in  1  load PC from br_target
br_link  in  1  with br_en: LR <= PC+PC_STEP
br_target  in  DATA_W  branch target
flag_we  in  4  per-flag write mask {N,Z,C,V}
flag_in  in  4  new flag values {N,Z,C,V}
hold  in  1  stall: suppress all state updates
pc  out  DATA_W  current PC (r15)
cpsr  out  DATA_W  CPSR; flags in [DATA_W-1:DATA_W-4], rest zero

Behaviour:
- Reset (reset low, async): all registers 0 except r13 = SP_RESET; cpsr = 0; pc = 0. rd_data follows reset contents immediately.
- Reads combinational: rd_data[k] = reg[rd_addr[k]]; reading r15 returns current PC (no pipeline offset).
- Writes on posedge clk when reset high and hold low; hold high freezes all registers, PC and CPSR.
- Same-cycle A and B to same address: port A wins.
- PC next-value priority (highest first): br_en -> br_target; wa/wb write to r15 -> that data (A over B); pc_inc -> pc + PC_STEP modulo 2^DATA_W; else hold.
- br_en with br_link: LR (r14) <= old pc + PC_STEP (wraps); overrides any wa/wb write to r14 that cycle. br_link without br_en ignored.
- CPSR: for each bit i with flag_we[i]=1, flag <= flag_in[i]; others retain. Low bits always read 0.
- Arithmetic unsigned, modulo 2^DATA_W; no overflow indication.
- Reset asserted mid-cycle: state cleared immediately; first write accepted on first posedge after deassertion.

Optional Feature:
Macro CPU_REGFILE_BYPASS_EN. Defined: rd_data[k] forwards the value being written this cycle (wa/wb, same priority, link and PC rules included) when rd_addr[k] matches and hold low — write-through read. Undefined: reads return stored value only; new value visible the cycle after the write.

Decomposition:
- Package cpu_pkg: register index constants (REG_SP=13, REG_LR=14, REG_PC=15), flag bit positions (FLAG_N..FLAG_V), flag count 4, address-width function.
- One sub-module natural: cpu_cpsr (masked flag register, reset, hold). PC/LR logic stays in cpu_regfile.

Test Plan:
- Reset: assert reset low mid-run -> all regs 0, r13=8'hFF, pc=0, cpsr=0 without a clock edge.
- Write/read: wa r3<=8'h5A, next cycle rd_addr0=3 -> 8'h5A; wa and wb both to r3 (8'h11, 8'h22) -> r3=8'h11.
- PC: pc=8'hFF, pc_inc -> 8'h00; br_en br_target=8'h40 with pc_inc -> pc=8'h40.
- Branch-with-link: pc=8'h10, br_en br_link target=8'h80, wa r14<=8'h33 -> pc=8'h80, r14=8'h11.
- Flags/hold: flag_we=4'b1010 flag_in=4'b1111 -> cpsr=8'hA0; hold high with wa r5<=8'h77 and pc_inc -> no change.
- Bypass (macro on): wa r7<=8'h9C, rd_addr1=7 same cycle -> rd_data1=8'h9C; macro off -> old r7 value.
